// File: rtl/bamf_outport_capture.sv
`default_nettype none
// ============================================================================
// Module      : bamf_outport_capture
// Description : Captures BAMF outport writes with a cycle stamp relative to
//               program start and buffers them in a FWFT FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module bamf_outport_capture #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_start,
    input  logic                       halt,
    input  logic                       out_we,
    input  logic [DATA_W-1:0]          out_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           rd_cycles,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic                       running,
    output logic [CNT_W-1:0]           cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + CNT_W;
    localparam logic [CW-1:0]    c_depth   = CW'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  w_cycles_nxt;
    logic [CNT_W-1:0]  w_cycles_inc;
    logic [CNT_W-1:0]  w_stamp;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_valid;
    logic              r_full;
    logic              r_overflow;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [EW-1:0]     w_head;

    assign w_cycles_inc = (r_cycles == c_cnt_max) ? r_cycles : r_cycles + CNT_W'(1);

    // Counter FSM: run_start dominates halt; halt lets the counter advance once more.
    always_comb begin
        w_state_nxt  = r_state;
        w_cycles_nxt = r_cycles;
        if (run_start) begin
            w_state_nxt  = ST_RUN;
            w_cycles_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_cycles_nxt = w_cycles_inc;
                    if (halt) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    // The stamp is the value the counter reaches on the capturing edge.
    assign w_stamp = run_start           ? '0 :
                     (r_state == ST_RUN) ? w_cycles_inc : r_cycles;

    assign w_pop  = r_valid & rd_ready;
    assign w_push = out_we & (~r_full | w_pop);
    assign w_drop = out_we & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == c_depth);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (run_start) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is written only on an accepted push, so X on an idle bus never lands.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {out_data, w_stamp};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign rd_valid  = r_valid;
    assign rd_data   = r_valid ? w_head[EW-1:CNT_W] : '0;
    assign rd_cycles = r_valid ? w_head[CNT_W-1:0]  : '0;
    assign count     = r_count;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign running   = (r_state == ST_RUN);
    assign cycles    = r_cycles;

endmodule
`default_nettype wire
